// File: rtl/fb_serializer_if.sv
// Frame-in / lane-stream-out bundle for fb_serializer.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface fb_serializer_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NOF_CHANNEL = 128
);
  localparam int unsigned LANES   = NOF_CHANNEL / 2;
  localparam int unsigned IDX_W   = $clog2(LANES);
  localparam int unsigned FRAME_W = DATA_WIDTH * LANES;
  localparam int unsigned CNT_W   = 16;

  logic [FRAME_W-1:0]    data_in;
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [IDX_W-1:0]      chan_idx;
  logic                  data_out_first;
  logic                  data_out_last;
  logic                  overflow;
  logic [CNT_W-1:0]      drop_cnt;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_out, data_out_valid, chan_idx, data_out_first, data_out_last,
           overflow, drop_cnt
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_out, data_out_valid, chan_idx, data_out_first, data_out_last,
           overflow, drop_cnt
  );
endinterface

// File: rtl/fb_serializer.sv
// Ping-pong buffered serializer: packed per-lane frame in, one lane per cycle out.
// Frames arriving while both buffers are occupied are dropped and counted.
module fb_serializer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NOF_CHANNEL = 128
) (
  input  logic           clk_data,
  input  logic           rst,
  fb_serializer_if.slave bus
);
  localparam int unsigned LANES = NOF_CHANNEL / 2;
  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] frame_t;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  frame_t           frame_q [2];
  frame_t           frame_d [2];
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] lane_q, lane_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   out_valid;
  logic   transfer;
  logic   rel;
  logic   acc;
  frame_t rd_frame;

  always_ff @(posedge clk_data or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      frame_q[0] <= '0;
      frame_q[1] <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      frame_q[0] <= frame_d[0];
      frame_q[1] <= frame_d[1];
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Occupancy FSM, buffer write and lane/read-pointer advance.
  always_comb begin
    state_d    = state_q;
    frame_d[0] = frame_q[0];
    frame_d[1] = frame_q[1];
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    lane_d     = lane_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    out_valid = (state_q != ST_EMPTY);
    transfer  = out_valid & bus.data_out_ready;
    rel       = transfer & (lane_q == LAST_LANE);
    // A releasing slot can take the incoming frame in the same cycle.
    acc       = bus.data_in_valid & ((state_q != ST_FULL) | rel);

    if (acc) begin
      if (wr_sel_q) frame_d[1] = bus.data_in;
      else          frame_d[0] = bus.data_in;
      wr_sel_d = ~wr_sel_q;
    end else if (bus.data_in_valid) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    if (rel) begin
      lane_d   = '0;
      rd_sel_d = ~rd_sel_q;
    end else if (transfer) begin
      lane_d = lane_q + IDX_W'(1);
    end

    case (state_q)
      ST_EMPTY: if (acc) state_d = ST_ONE;
      ST_ONE: begin
        if (acc && !rel)      state_d = ST_FULL;
        else if (rel && !acc) state_d = ST_EMPTY;
      end
      ST_FULL:  if (rel && !acc) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Outputs decode registered state only; no path from ready or data_in.
  assign rd_frame           = rd_sel_q ? frame_q[1] : frame_q[0];
  assign bus.data_out_valid = (state_q != ST_EMPTY);
  assign bus.data_out       = bus.data_out_valid ? rd_frame[lane_q] : '0;
  assign bus.chan_idx       = lane_q;
  assign bus.data_out_first = bus.data_out_valid & (lane_q == '0);
  assign bus.data_out_last  = bus.data_out_valid & (lane_q == LAST_LANE);
  assign bus.overflow       = overflow_q;
  assign bus.drop_cnt       = drop_cnt_q;
endmodule

// File: doc/fb_serializer.md
# fb_serializer

Converts the packed per-lane filterbank frame (64 lanes × 16 bit by default) into a one-lane-per-cycle stream with valid/ready handshake. It sits downstream of the channel averaging stage and feeds narrow consumers: packetiser, threshold detector, DMA. Two frame buffers (ping-pong) absorb back-pressure. A frame that arrives with both buffers occupied is dropped and counted.

## Interface

- DATA_WIDTH, 16, bits per lane sample
- NOF_CHANNEL, 128, channel count; lanes per frame L = NOF_CHANNEL/2
- clk_data  in  1  single clock for all logic
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH*NOF_CHANNEL/2  packed frame; lane m at bits [m*DATA_WIDTH +: DATA_WIDTH]
- data_in_valid  in  1  one-cycle frame strobe; no back-pressure on this side
- data_out  out  DATA_WIDTH  current lane sample; forced 0 when data_out_valid=0
- data_out_valid  out  1  stream valid
- data_out_ready  in  1  consumer ready; transfer = valid & ready
- chan_idx  out  $clog2(L)  lane index of data_out
- data_out_first  out  1  valid & chan_idx==0
- data_out_last  out  1  valid & chan_idx==L-1
- overflow  out  1  sticky; set on any dropped frame
- drop_cnt  out  16  dropped-frame count, saturates at 0xFFFF

## Operation

- Storage: two L×DATA_WIDTH registers buf[0], buf[1]. Pointers wr_sel and rd_sel, 1 bit each. Lane counter lane, 0..L-1.
- Occupancy FSM, states EMPTY (0 frames), ONE (1), FULL (2).
- Definitions: acc = data_in_valid & (state!=FULL | rel). rel = transfer & lane==L-1.
- On acc: buf[wr_sel] <= data_in, and wr_sel toggles.
- On data_in_valid & !acc: the frame is dropped. overflow <= 1. drop_cnt increments unless already 0xFFFF.
- Transitions:
  - EMPTY: acc→ONE
  - ONE: acc&!rel→FULL; rel&!acc→EMPTY; otherwise stay
  - FULL: rel&!acc→ONE; rel&acc→FULL; otherwise stay
- Read side:
  - data_out_valid = (state!=EMPTY)
  - data_out = buf[rd_sel][lane]
  - chan_idx = lane
- Each transfer increments lane. On rel, lane wraps to 0 and rd_sel toggles.
- Back-pressure: with ready low, data_out, chan_idx and valid hold stable. Valid never drops mid-frame.
- No bubble between frames. When FULL and the last lane transfers, lane 0 of the next frame is presented the following cycle.
- Simultaneous rel and data_in_valid in FULL: the new frame is accepted into the slot being released (wr_sel == rd_sel at that point). No drop occurs.

## Timing

- Reset (rst=0, asynchronous) clears:
  - state=EMPTY, wr_sel=0, rd_sel=0, lane=0
  - overflow=0, drop_cnt=0
  - buf contents cleared to 0
- Resulting output values during reset: data_out_valid=0, data_out=0, chan_idx=0, first=0, last=0.
- Reset mid-frame discards all buffered frames and any partially streamed frame. The first frame accepted after release streams from lane 0.
- Latency: data_in_valid in cycle N while EMPTY → lane 0 valid in cycle N+1.
- Frame duration with ready held high: exactly L cycles. Sustained throughput is 1 frame per L cycles.
- Counters and flags update on the rising edge. Outputs are decoded from registered state only; no combinational path from data_out_ready or data_in to any output.
- overflow and drop_cnt change in the cycle after the drop strobe. They clear only on reset.

## Test plan

- Single frame, lanes loaded with value = lane index (0x0000..0x003F), ready=1 → valid in cycles N+1..N+64. data_out = chan_idx. first in cycle N+1, last in cycle N+64. Then EMPTY.
- Two frames (A = 0x1000+m, B = 0x2000+m) 64 cycles apart, ready=1 → 128 consecutive valid cycles, A then B, no bubble.
- ready toggled 1/0 each cycle over one frame → 128 cycles total. Each lane appears exactly once, in order. Outputs are stable while ready=0.
- ready=0, three frames strobed → first two retained, third dropped. overflow=1, drop_cnt=1. Then ready=1 → 128 samples, frames 1 and 2 only.
- FULL with a new frame strobed in the same cycle as last-lane transfer → new frame accepted, drop_cnt unchanged, streamed immediately after the remaining buffered frame.
- rst pulled low at lane 30 → valid=0, data_out=0 immediately. After release, a new frame streams from lane 0 with drop_cnt=0.
